mem_rr_arbiter: RTL and testbench

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_rr_pick.sv | 23 ++
 rtl/mem_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
// State encoding, requester count and the timeout read-data pattern.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    // Extract one requester's fields from the packed per-requester buses.
    function automatic mem_req_t req_slice(
        input logic        idx,
        input logic [1:0]  instr,
        input logic [63:0] addr,
        input logic [63:0] wdata,
        input logic [7:0]  wstrb
    );
        mem_req_t r;
        r.instr = idx ? instr[1]       : instr[0];
        r.addr  = idx ? addr[63:32]    : addr[31:0];
        r.wdata = idx ? wdata[63:32]   : wdata[31:0];
        r.wstrb = idx ? wstrb[7:4]     : wstrb[3:0];
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin grant picker: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               last_grant,
    output logic               grant,
    output logic               any_valid
);

    always_comb begin
        grant     = 1'b0;
        any_valid = |req_valid;
        unique case (1'b1)
            (req_valid == 2'b11): grant = ~last_grant;
            (req_valid == 2'b10): grant = 1'b1;
            (req_valid == 2'b01): grant = 1'b0;
            default:              grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter onto one native memory port.
// Optional bus timeout abort is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_instr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [1:0]  req_ready,
    output logic [31:0] req_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    logic [1:0] state;
    logic       last_grant;
    logic       grant;
    logic       pick_g;
    logic       pick_any;
    mem_req_t   pick_req;
    logic       tmo_hit;

    mem_arb_rr_pick u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick_g),
        .any_valid  (pick_any)
    );

    assign pick_req = req_slice(pick_g, req_instr, req_addr,
                                req_wdata, req_wstrb);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counts completed BUSY cycles; restarts from zero on every entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state != ST_BUSY) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            mem_valid  <= 1'b0;
            mem_instr  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            req_ready  <= '0;
            req_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_g;
                        last_grant <= pick_g;
                        mem_instr  <= pick_req.instr;
                        mem_addr   <= pick_req.addr;
                        mem_wdata  <= pick_req.wdata;
                        mem_wstrb  <= pick_req.wstrb;
                        mem_valid  <= 1'b1;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A real completion beats a timeout on the same cycle.
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        req_rdata <= mem_rdata;
                        req_ready <= grant ? 2'b10 : 2'b01;
                        state     <= ST_RESP;
                    end else if (tmo_hit) begin
                        mem_valid <= 1'b0;
                        req_rdata <= ERR_RDATA;
                        req_ready <= grant ? 2'b10 : 2'b01;
`ifdef MEM_ARB_TIMEOUT_EN
                        err       <= 1'b1;
`endif
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    req_ready <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    err       <= 1'b0;
`endif
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: vector table plus corner sequences.
// Build with MEM_ARB_TIMEOUT_EN to exercise the timeout abort path.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_instr;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_ready;
    logic [31:0] req_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_instr (req_instr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [1:0]  instr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_instr;
        logic [1:0]  e_ready;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the arbiter idle.
    task automatic do_txn(input vec_t v);
        req_valid = v.rv;
        req_instr = v.instr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        @(negedge clk);
        req_valid = 2'b00;
        chk("txn_mem_valid", 64'(mem_valid), 64'd1);
        chk("txn_mem_addr", 64'(mem_addr), 64'(v.e_addr));
        chk("txn_mem_wdata", 64'(mem_wdata), 64'(v.e_wdata));
        chk("txn_mem_wstrb", 64'(mem_wstrb), 64'(v.e_wstrb));
        chk("txn_mem_instr", 64'(mem_instr), 64'(v.e_instr));
        for (int i = 0; i < v.lat; i++) begin
            @(negedge clk);
            chk("txn_wait_valid", 64'(mem_valid), 64'd1);
        end
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("txn_ready", 64'(req_ready), 64'(v.e_ready));
        chk("txn_rdata", 64'(req_rdata), 64'(v.rdata));
        chk("txn_valid_drop", 64'(mem_valid), 64'd0);
        @(negedge clk);
        chk("txn_ready_clear", 64'(req_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_seq [4];
        int         npulse;
        logic       seen_grant;

        vecs[0] = '{2'b01, 2'b01, {32'h0, 32'h100}, 64'h0, 8'h00, 2,
                    32'h1234_5678, 32'h100, 32'h0, 4'h0, 1'b1, 2'b01};
        vecs[1] = '{2'b10, 2'b00, {32'h2000, 32'h0},
                    {32'hDEAD_BEEF, 32'h0}, 8'h30, 0,
                    32'h0, 32'h2000, 32'hDEAD_BEEF, 4'h3, 1'b0, 2'b10};
        vecs[2] = '{2'b11, 2'b10, {32'h400, 32'h300},
                    {32'h22, 32'h11}, 8'hF0, 1,
                    32'hCAFE_0001, 32'h300, 32'h11, 4'h0, 1'b0, 2'b01};
        vecs[3] = '{2'b11, 2'b10, {32'h400, 32'h300},
                    {32'h22, 32'h11}, 8'hF0, 1,
                    32'hCAFE_0002, 32'h400, 32'h22, 4'hF, 1'b1, 2'b10};
        vecs[4] = '{2'b01, 2'b00, {32'h0, 32'hFFFF_FFFC},
                    {32'h0, 32'hA5A5_A5A5}, 8'h0F, 5,
                    32'h0, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'hF, 1'b0, 2'b01};
        vecs[5] = '{2'b11, 2'b11, {32'h8, 32'h4}, {32'h2, 32'h1}, 8'h00, 3,
                    32'h55AA_55AA, 32'h8, 32'h2, 4'h0, 1'b1, 2'b10};

        resetn    = 1'b0;
        req_valid = '0;
        req_instr = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_req_rdata", 64'(req_rdata), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_mem_instr", 64'(mem_instr), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i]);
        end

        // Requester 1 writes while requester 0 churns its inputs.
        req_valid = 2'b10;
        req_instr = 2'b00;
        req_addr  = {32'h1000_0000, 32'h0};
        req_wdata = {32'h41, 32'h0};
        req_wstrb = 8'hF0;
        @(negedge clk);
        chk("wh_mem_addr", 64'(mem_addr), 64'h1000_0000);
        req_valid = 2'b01;
        req_instr = 2'b01;
        req_addr  = {32'hBAD0, 32'h999};
        req_wdata = {32'h0, 32'h77};
        req_wstrb = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wh_addr_hold", 64'(mem_addr), 64'h1000_0000);
            chk("wh_wdata_hold", 64'(mem_wdata), 64'h41);
            chk("wh_wstrb_hold", 64'(mem_wstrb), 64'hF);
            chk("wh_instr_hold", 64'(mem_instr), 64'h0);
        end
        req_valid = 2'b00;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("wh_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        chk("wh_ready_clear", 64'(req_ready), 64'h0);

        // Reset in the middle of a transfer, then a sustained tie.
        req_valid = 2'b10;
        req_addr  = {32'h5000, 32'h0};
        req_wstrb = 8'h00;
        @(negedge clk);
        chk("mid_busy", 64'(mem_valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid_async_drop", 64'(mem_valid), 64'd0);
        chk("mid_no_ready", 64'(req_ready), 64'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        req_valid = 2'b11;
        req_addr  = {32'h700, 32'h600};
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        resetn = 1'b1;

        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;
        npulse     = 0;
        seen_grant = 1'b0;
        for (int c = 0; c < 60 && npulse < 4; c++) begin
            @(negedge clk);
            if (mem_valid && !seen_grant) begin
                seen_grant = 1'b1;
                chk("post_rst_grant0", 64'(mem_addr), 64'h600);
            end
            if (req_ready != 2'b00) begin
                chk("tie_pulse", 64'(req_ready), 64'(exp_seq[npulse]));
                npulse++;
            end
        end
        req_valid = 2'b00;
        mem_ready = 1'b0;
        chk("tie_pulse_count", 64'(npulse), 64'd4);
        repeat (2) @(negedge clk);
        chk("tie_idle_ready", 64'(req_ready), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'hABC};
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("tmo_still_valid", 64'(mem_valid), 64'd1);
        chk("tmo_no_err_yet", 64'(err), 64'd0);
        @(negedge clk);
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_ready", 64'(req_ready), 64'h1);
        chk("tmo_rdata", 64'(req_rdata), 64'hFFFF_FFFF);
        chk("tmo_valid_drop", 64'(mem_valid), 64'd0);
        @(negedge clk);
        chk("tmo_err_clear", 64'(err), 64'd0);
        chk("tmo_ready_clear", 64'(req_ready), 64'd0);

        req_valid = 2'b10;
        req_addr  = {32'hDEF, 32'h0};
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 32'h2468;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("tie_tmo_err", 64'(err), 64'd0);
        chk("tie_tmo_ready", 64'(req_ready), 64'h2);
        chk("tie_tmo_rdata", 64'(req_rdata), 64'h2468);
        @(negedge clk);
`else
        req_valid = 2'b01;
        req_addr  = {32'h0, 32'hABC};
        @(negedge clk);
        req_valid = 2'b00;
        repeat (1000) @(negedge clk);
        chk("notmo_valid", 64'(mem_valid), 64'd1);
        chk("notmo_err", 64'(err), 64'd0);
        chk("notmo_ready", 64'(req_ready), 64'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h1357;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("notmo_final_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
